// File: rtl/antsdr_rx_pkg.sv
// Shared types for the AD9361 receive sample path: sc16 sample word and 12->16 bit packing.
package antsdr_rx_pkg;

    localparam int SC16_W = 16;
    localparam int ADC_W  = 12;

    typedef struct packed {
        logic              tuser;
        logic [SC16_W-1:0] i;
        logic [SC16_W-1:0] q;
    } rx_word_t;

    localparam int RX_WORD_W = 1 + 2 * SC16_W;

    // Left-justify the ADC code so full scale maps onto the sc16 range; the low bits stay zero.
    function automatic rx_word_t sc16_pack(input logic [ADC_W-1:0] i12,
                                           input logic [ADC_W-1:0] q12,
                                           input logic             chan);
        rx_word_t w;
        w.tuser = chan;
        w.i     = {i12, {(SC16_W - ADC_W){1'b0}}};
        w.q     = {q12, {(SC16_W - ADC_W){1'b0}}};
        return w;
    endfunction

endpackage

// File: rtl/antsdr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: block RAM plus an output register that prefetches the head.
module antsdr_sync_fifo #(
    parameter int AW = 9,
    parameter int DW = 33
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    output logic [AW:0]   o_count
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_wr;
    logic          w_pop;
    logic          w_load;
    logic [AW-1:0] w_rd_addr;
    logic [AW:0]   w_count_after_pop;

    assign w_wr              = i_wr_en & (r_count != (AW + 1)'(DEPTH));
    assign w_pop             = r_dout_valid & i_rd_en;
    assign w_load            = w_pop | ~r_dout_valid;
    assign w_rd_addr         = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_count_after_pop = r_count - {{AW{1'b0}}, w_pop};

    // NOTE: RAM and its output register carry no reset so they map onto block RAM; validity lives in r_dout_valid.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
        if (w_load) begin
            r_dout <= r_mem[w_rd_addr];
        end
    end

    // The head word only becomes visible once it was written on an earlier edge, so a new write is never bypassed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count      <= w_count_after_pop + {{AW{1'b0}}, w_wr};
            r_dout_valid <= (w_count_after_pop != '0);
        end
    end

    assign o_rd_data  = r_dout_valid ? r_dout : '0;
    assign o_rd_valid = r_dout_valid;
    assign o_count    = r_count;

endmodule

// File: rtl/antsdr_rx_sample_fifo.sv
// AD9361 receive sample buffer: strobe accept/drop, MIMO ch1 hold, overflow reporting and AXI-Stream packetising.
module antsdr_rx_sample_fifo
    import antsdr_rx_pkg::*;
#(
    parameter int FIFO_AW = 9,
    parameter int SPP     = 256,
    parameter int OVF_CW  = 16
) (
    input  logic              radio_clk,
    input  logic              radio_rst_n,
    input  logic              enable,
    input  logic              mimo,
    input  logic [ADC_W-1:0]  rx_i0,
    input  logic [ADC_W-1:0]  rx_q0,
    input  logic [ADC_W-1:0]  rx_i1,
    input  logic [ADC_W-1:0]  rx_q1,
    input  logic              rx_stb,
    input  logic              ovf_clear,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              ovf_sticky,
    output logic [OVF_CW-1:0] ovf_count
);

    localparam int          DEPTH    = 2 ** FIFO_AW;
    localparam int          FW       = FIFO_AW + 2;
    localparam logic [15:0] LAST_IDX = 16'(SPP - 1);

    logic              r_ch1_pend;
    rx_word_t          r_ch1_word;
    logic              r_ovf_sticky;
    logic [OVF_CW-1:0] r_ovf_count;
    logic [15:0]       r_pkt_cnt;

    logic [FIFO_AW:0]  w_count;
    logic [FW-1:0]     w_fill;
    logic              w_strobe;
    logic              w_room;
    logic              w_accept;
    logic              w_drop;
    logic              w_wr_en;
    logic              w_rd_valid;
    logic              w_xfer;
    rx_word_t          w_wr_word;
    rx_word_t          w_rd_word;

    assign w_strobe  = enable & rx_stb;
    assign w_fill    = FW'(w_count) + FW'(r_ch1_pend) + (mimo ? FW'(2) : FW'(1));
    assign w_room    = (w_fill <= FW'(DEPTH));
    // The write port is busy with ch1 while it is pending, so any strobe in that cycle is dropped whole.
    assign w_accept  = w_strobe & ~r_ch1_pend & w_room;
    assign w_drop    = w_strobe & ~w_accept;
    assign w_wr_en   = w_accept | r_ch1_pend;
    assign w_wr_word = r_ch1_pend ? r_ch1_word : sc16_pack(rx_i0, rx_q0, 1'b0);

    always_ff @(posedge radio_clk) begin
        if (w_accept & mimo) begin
            r_ch1_word <= sc16_pack(rx_i1, rx_q1, 1'b1);
        end
    end

    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            r_ch1_pend <= 1'b0;
        end else begin
            r_ch1_pend <= w_accept & mimo;
        end
    end

    // A clear in the same cycle as a drop still records that drop.
    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_count  <= '0;
        end else if (ovf_clear) begin
            r_ovf_sticky <= w_drop;
            r_ovf_count  <= OVF_CW'(w_drop);
        end else if (w_drop) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_count != '1) begin
                r_ovf_count <= r_ovf_count + 1'b1;
            end
        end
    end

    antsdr_sync_fifo #(
        .AW (FIFO_AW),
        .DW (RX_WORD_W)
    ) u_fifo (
        .i_clk      (radio_clk),
        .i_rst_n    (radio_rst_n),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (w_wr_word),
        .i_rd_en    (m_tready),
        .o_rd_data  (w_rd_word),
        .o_rd_valid (w_rd_valid),
        .o_count    (w_count)
    );

    assign w_xfer = w_rd_valid & m_tready;

    // Packet position follows words actually transferred, independent of FIFO wrap or enable gaps.
    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            r_pkt_cnt <= '0;
        end else if (w_xfer) begin
            r_pkt_cnt <= (r_pkt_cnt == LAST_IDX) ? '0 : r_pkt_cnt + 1'b1;
        end
    end

    assign m_tdata    = {w_rd_word.i, w_rd_word.q};
    assign m_tuser    = w_rd_word.tuser;
    assign m_tvalid   = w_rd_valid;
    assign m_tlast    = w_rd_valid & (r_pkt_cnt == LAST_IDX);
    assign ovf_sticky = r_ovf_sticky;
    assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_antsdr_rx_sample_fifo.sv
// Directed bench for antsdr_rx_sample_fifo with a small FIFO, SPP=4 and a 2-bit overflow counter.
module tb_antsdr_rx_sample_fifo;

    localparam int FIFO_AW = 3;
    localparam int SPP     = 4;
    localparam int OVF_CW  = 2;

    typedef struct packed {
        logic        last;
        logic        user;
        logic [31:0] data;
    } exp_t;

    logic              radio_clk = 1'b0;
    logic              radio_rst_n;
    logic              enable;
    logic              mimo;
    logic [11:0]       rx_i0, rx_q0, rx_i1, rx_q1;
    logic              rx_stb;
    logic              ovf_clear;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              m_tuser;
    logic              ovf_sticky;
    logic [OVF_CW-1:0] ovf_count;

    int   n_checks = 0;
    int   n_bad    = 0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    antsdr_rx_sample_fifo #(
        .FIFO_AW (FIFO_AW),
        .SPP     (SPP),
        .OVF_CW  (OVF_CW)
    ) dut (
        .radio_clk   (radio_clk),
        .radio_rst_n (radio_rst_n),
        .enable      (enable),
        .mimo        (mimo),
        .rx_i0       (rx_i0),
        .rx_q0       (rx_q0),
        .rx_i1       (rx_i1),
        .rx_q1       (rx_q1),
        .rx_stb      (rx_stb),
        .ovf_clear   (ovf_clear),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .ovf_sticky  (ovf_sticky),
        .ovf_count   (ovf_count)
    );

    always #5 radio_clk = ~radio_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge radio_clk);
        #1;
        if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic u, input logic l);
        exp_q.push_back({l, u, d});
    endtask

    task automatic strobe(input logic m, input logic [11:0] i0, input logic [11:0] q0,
                          input logic [11:0] i1, input logic [11:0] q1);
        mimo   = m;
        rx_i0  = i0;
        rx_q0  = q0;
        rx_i1  = i1;
        rx_q1  = q1;
        rx_stb = 1'b1;
        tick();
        rx_stb = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
        check(tag, exp_q.size(), 0);
        tick();
        tick();
        check({tag, "_idle"}, m_tvalid, 1'b0);
    endtask

    // Scoreboard: every transfer must match the next hand-written expected word.
    always @(negedge radio_clk) begin
        if (radio_rst_n && m_tvalid && m_tready) begin
            check("word_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("tdata", m_tdata, e.data);
                check("tuser", m_tuser, e.user);
                check("tlast", m_tlast, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        radio_rst_n = 1'b0;
        enable      = 1'b1;
        mimo        = 1'b0;
        rx_i0 = '0; rx_q0 = '0; rx_i1 = '0; rx_q1 = '0;
        rx_stb      = 1'b0;
        ovf_clear   = 1'b0;
        m_tready    = 1'b0;

        repeat (3) @(posedge radio_clk);
        #1;
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tdata", m_tdata, 32'h0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tuser", m_tuser, 1'b0);
        check("rst_sticky", ovf_sticky, 1'b0);
        check("rst_count", ovf_count, 2'd0);
        radio_rst_n = 1'b1;
        tick();

        // SISO with ready high: latency, conversion, tlast on 4th word.
        m_tready = 1'b1;
        expect_word(32'h7FF0_8000, 1'b0, 1'b0);
        strobe(1'b0, 12'h7FF, 12'h800, 12'h000, 12'h000);
        check("lat_cycle1_tvalid", m_tvalid, 1'b0);
        tick();
        check("lat_cycle2_tvalid", m_tvalid, 1'b1);
        check("lat_cycle2_tdata", m_tdata, 32'h7FF0_8000);
        expect_word(32'h0010_FFF0, 1'b0, 1'b0);
        strobe(1'b0, 12'h001, 12'hFFF, 12'h000, 12'h000);
        expect_word(32'h7FF0_8000, 1'b0, 1'b0);
        strobe(1'b0, 12'h7FF, 12'h800, 12'h000, 12'h000);
        expect_word(32'h0010_FFF0, 1'b0, 1'b1);
        strobe(1'b0, 12'h001, 12'hFFF, 12'h000, 12'h000);
        enable = 1'b0;
        strobe(1'b0, 12'h555, 12'h555, 12'h000, 12'h000);
        enable = 1'b1;
        wait_drain("siso_drain", 40);
        check("siso_ovf_count", ovf_count, 2'd0);
        check("siso_ovf_sticky", ovf_sticky, 1'b0);

        // Ten words under random ready; packet counter starts at 0, ends at 2.
        rand_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_word(32'h1000_2000 + (k << 20) + (k << 4), 1'b0, (k == 3 || k == 7));
            strobe(1'b0, 12'h100 + 12'(k), 12'h200 + 12'(k), 12'h000, 12'h000);
            tick();
            tick();
        end
        wait_drain("spp_drain", 200);
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        check("spp_ovf_count", ovf_count, 2'd0);

        // MIMO every other cycle; counter at 2 puts tlast on the 2nd and 6th words.
        for (int s = 0; s < 3; s++) begin
            expect_word(32'h1230_4560, 1'b0, 1'b0);
            expect_word(32'hABC0_DEF0, 1'b1, (s != 1));
            strobe(1'b1, 12'h123, 12'h456, 12'hABC, 12'hDEF);
            mimo = 1'b0;
            if (s == 2) enable = 1'b0;
            tick();
            enable = 1'b1;
        end
        wait_drain("mimo_drain", 40);
        check("mimo_ovf_count", ovf_count, 2'd0);

        // Overflow: ready low, ten SISO strobes into an 8-deep FIFO.
        m_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) expect_word(32'h3000_0000 + (k << 20) + (k << 4), 1'b0, (k == 3 || k == 7));
            strobe(1'b0, 12'h300 + 12'(k), 12'h000 + 12'(k), 12'h000, 12'h000);
        end
        check("ovf_count_2", ovf_count, 2'd2);
        check("ovf_sticky_set", ovf_sticky, 1'b1);
        check("hold_tdata_a", m_tdata, 32'h3000_0000);
        tick();
        tick();
        tick();
        check("hold_tdata_b", m_tdata, 32'h3000_0000);
        check("hold_tvalid", m_tvalid, 1'b1);

        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("clear_count", ovf_count, 2'd0);
        check("clear_sticky", ovf_sticky, 1'b0);

        // Seven stored: a MIMO strobe needs two slots and is dropped whole.
        strobe(1'b1, 12'h777, 12'h777, 12'h888, 12'h888);
        mimo = 1'b0;
        check("mimo_drop_count", ovf_count, 2'd1);
        expect_word(32'h5A50_A5A0, 1'b0, 1'b0);
        strobe(1'b0, 12'h5A5, 12'hA5A, 12'h000, 12'h000);
        check("siso_fill_count", ovf_count, 2'd1);
        strobe(1'b0, 12'h999, 12'h999, 12'h000, 12'h000);
        check("full_drop_count", ovf_count, 2'd2);

        ovf_clear = 1'b1;
        strobe(1'b0, 12'h999, 12'h999, 12'h000, 12'h000);
        ovf_clear = 1'b0;
        check("clear_drop_count", ovf_count, 2'd1);
        check("clear_drop_sticky", ovf_sticky, 1'b1);
        for (int d = 0; d < 4; d++) strobe(1'b0, 12'h999, 12'h999, 12'h000, 12'h000);
        check("sat_count", ovf_count, 2'd3);

        m_tready = 1'b1;
        wait_drain("ovf_drain", 40);

        // Reset mid-packet with ch1 pending; packet counter currently 1.
        m_tready = 1'b0;
        strobe(1'b0, 12'h111, 12'h222, 12'h000, 12'h000);
        strobe(1'b1, 12'h333, 12'h444, 12'h555, 12'h666);
        mimo = 1'b0;
        check("pre_rst_tvalid", m_tvalid, 1'b1);
        radio_rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_tvalid, 1'b0);
        check("mid_rst_tdata", m_tdata, 32'h0);
        check("mid_rst_tlast", m_tlast, 1'b0);
        check("mid_rst_tuser", m_tuser, 1'b0);
        check("mid_rst_sticky", ovf_sticky, 1'b0);
        check("mid_rst_count", ovf_count, 2'd0);
        exp_q.delete();
        tick();
        tick();
        radio_rst_n = 1'b1;
        tick();

        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_word(32'hF000_0F00 + (k << 20) + (k << 4), 1'b0, (k == 3));
            strobe(1'b0, 12'hF00 + 12'(k), 12'h0F0 + 12'(k), 12'h000, 12'h000);
        end
        wait_drain("post_rst_drain", 40);
        check("post_rst_ovf_count", ovf_count, 2'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
